// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared instruction/data RAM port arbiter and access sequencer; optional IF fairness via MEM_ARB_FAIR_EN
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

    // Counter reload value: the access occupies MEM_LAT cycles, ending when the count reaches zero.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    stateT      state;
    logic       ownerMem;
    logic [3:0] latCnt;
    logic       memReq;
    logic       grantMem;

    assign memReq = mem_read | mem_write;

`ifdef MEM_ARB_FAIR_EN
    logic ifStarved;

    // A starved fetch beats the memory stage once, giving alternation under contention.
    assign grantMem = memReq & ~(ifStarved & if_req);

    // Remember whether fetch was left waiting by the most recent grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifStarved <= 1'b0;
        end else if (state == IDLE && (memReq || if_req)) begin
            ifStarved <= grantMem & if_req;
        end
    end
`else
    // Memory stage always wins; fetch may starve under continuous load/store traffic.
    assign grantMem = memReq;
`endif

    // Stalls release in the ack cycle so the pipeline advances exactly when data is returned.
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = memReq & ~mem_ack;

    // Access sequencer: grant in IDLE, hold the RAM request for MEM_LAT cycles, then pulse the owner's ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ownerMem  <= 1'b0;
            latCnt    <= 4'd0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if_ack  <= 1'b0;
                    mem_ack <= 1'b0;
                    if (memReq || if_req) begin
                        ownerMem  <= grantMem;
                        ram_addr  <= grantMem ? mem_addr : if_addr;
                        ram_wdata <= grantMem ? mem_wdata : '0;
                        ram_we    <= grantMem & mem_write;
                        ram_en    <= 1'b1;
                        latCnt    <= LAT_LOAD;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (latCnt == 4'd0) begin
                        if (!ram_we) begin
                            if (ownerMem) begin
                                mem_rdata <= ram_rdata;
                            end else begin
                                if_rdata <= ram_rdata;
                            end
                        end
                        if (ownerMem) begin
                            mem_ack <= 1'b1;
                        end else begin
                            if_ack <= 1'b1;
                        end
                        ram_en <= 1'b0;
                        ram_we <= 1'b0;
                        state  <= RESP;
                    end else begin
                        latCnt <= latCnt - 4'd1;
                    end
                end
                RESP: begin
                    if_ack  <= 1'b0;
                    mem_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] ramArr [0:255];
    int          enRun = 0;
    int          nChecks = 0;
    int          nPass = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: read data is only valid on the last cycle of a MEM_LAT-long enable run.
    always @(posedge clk) enRun <= ram_en ? enRun + 1 : 0;
    assign ram_rdata = (ram_en && enRun == LAT - 1) ? ramArr[ram_addr[7:0]] : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    bit          ifAct, memAct, memRd, memWr, busy, gMem, gWe, winMem, starved;
    bit          expEn, expIfAck, expMemAck;
    int          freeAt, gCyc, kind;
    logic [15:0] gAddr, gWdata, gData, expIf, expMem;
    bit          ackQ[$];

    initial begin
        for (int i = 0; i < 256; i++) ramArr[i] = 16'($urandom);
        reset = 1'b1; if_req = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        if_addr = 16'h0; mem_addr = 16'h0; mem_wdata = 16'h0;

        // Reset with both requests pending
        for (int k = 0; k < 2; k++) begin
            nextCycle(); mid();
            check("rst_ram_en", ram_en, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_wdata", ram_wdata, 0);
            check("rst_if_ack", if_ack, 0);
            check("rst_mem_ack", mem_ack, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_mem_rdata", mem_rdata, 0);
            check("rst_stall_if", stall_if, 1);
            check("rst_stall_mem", stall_mem, 1);
        end
        nextCycle(); reset = 1'b0; if_req = 1'b0; mem_read = 1'b0; mid();
        check("idle_stall_if", stall_if, 0);

        // IF read
        nextCycle(); if_req = 1'b1; if_addr = 16'h0011; ramArr[8'h11] = 16'hBEEF; mid();
        check("ifrd_c0_stall", stall_if, 1);
        check("ifrd_c0_en", ram_en, 0);
        for (int k = 1; k <= 3; k++) begin
            nextCycle(); mid();
            check("ifrd_en", ram_en, k <= 2);
            check("ifrd_ack", if_ack, k == 3);
            check("ifrd_stall", stall_if, k <= 2);
            if (k <= 2) begin
                check("ifrd_addr", ram_addr, 16'h0011);
                check("ifrd_we", ram_we, 0);
            end else begin
                check("ifrd_data", if_rdata, 16'hBEEF);
            end
        end
        nextCycle(); if_req = 1'b0; mid();
        check("ifrd_ack_pulse", if_ack, 0);

        // MEM store
        nextCycle(); mem_write = 1'b1; mem_addr = 16'h0004; mem_wdata = 16'hAAAA; mid();
        check("st_c0_stall", stall_mem, 1);
        for (int k = 1; k <= 3; k++) begin
            nextCycle(); mid();
            check("st_en", ram_en, k <= 2);
            check("st_ack", mem_ack, k == 3);
            if (k <= 2) begin
                check("st_we", ram_we, 1);
                check("st_addr", ram_addr, 16'h0004);
                check("st_wdata", ram_wdata, 16'hAAAA);
            end else begin
                check("st_rdata_hold", mem_rdata, 0);
                check("st_stall", stall_mem, 0);
            end
        end
        nextCycle(); mem_write = 1'b0; ramArr[4] = 16'hAAAA; mid();

        // Contention: MEM first, then IF
        nextCycle();
        if_req = 1'b1; if_addr = 16'h0010; mem_read = 1'b1; mem_addr = 16'h0004;
        ramArr[4] = 16'h1234; ramArr[16] = 16'h5678; mid();
        for (int k = 1; k <= 7; k++) begin
            nextCycle();
            if (k == 4) mem_read = 1'b0;
            mid();
            check("ct_mem_ack", mem_ack, k == 3);
            check("ct_if_ack", if_ack, k == 7);
            check("ct_en", ram_en, k == 1 || k == 2 || k == 5 || k == 6);
            if (k <= 2) check("ct_addr_mem", ram_addr, 16'h0004);
            if (k == 5 || k == 6) check("ct_addr_if", ram_addr, 16'h0010);
            if (k == 3) check("ct_mem_data", mem_rdata, 16'h1234);
            if (k == 7) check("ct_if_data", if_rdata, 16'h5678);
            check("ct_stall_if", stall_if, k != 7);
        end
        nextCycle(); if_req = 1'b0; mid();

        // Reset in the first ACCESS cycle of a MEM load
        nextCycle(); mem_read = 1'b1; mem_addr = 16'h0004; mid();
        nextCycle(); reset = 1'b1; mid();
        check("rma_c1_en", ram_en, 1);
        check("rma_c1_stall", stall_mem, 1);
        nextCycle(); reset = 1'b0; mid();
        check("rma_c2_en", ram_en, 0);
        check("rma_c2_ack", mem_ack, 0);
        for (int k = 3; k <= 5; k++) begin
            nextCycle(); mid();
            check("rma_en", ram_en, k <= 4);
            check("rma_ack", mem_ack, k == 5);
            if (k <= 4) check("rma_addr", ram_addr, 16'h0004);
            else check("rma_data", mem_rdata, 16'h1234);
        end
        nextCycle(); mem_read = 1'b0; mid();

        // Continuous contention: ack order depends on fairness
        nextCycle(); mem_read = 1'b1; mem_addr = 16'h0004; if_req = 1'b1; if_addr = 16'h0010;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) nextCycle();
            mid();
            if (mem_ack) ackQ.push_back(1'b1);
            if (if_ack) ackQ.push_back(1'b0);
        end
        nextCycle(); mem_read = 1'b0; if_req = 1'b0; mid();
        check("fair_count", ackQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FAIR_EN
            check("fair_order", (i < ackQ.size()) ? 32'(ackQ[i]) : 32'd2, (i % 2 == 0) ? 1 : 0);
`else
            check("fair_order", (i < ackQ.size()) ? 32'(ackQ[i]) : 32'd2, 1);
`endif
        end

        // Randomized traffic against a transaction-level model
        reset = 1'b1; nextCycle(); reset = 1'b0;
        ifAct = 0; memAct = 0; memRd = 0; memWr = 0; busy = 0; starved = 0;
        freeAt = 0; gCyc = 0; gMem = 0; gWe = 0; expIf = 16'h0; expMem = 16'h0;
        for (int c = 0; c < 1500; c++) begin
            if (c > 0) nextCycle();
            if (!ifAct && $urandom_range(0, 2) == 0) begin
                ifAct = 1; if_addr = 16'($urandom);
            end
            if (!memAct && $urandom_range(0, 2) == 0) begin
                memAct = 1; kind = $urandom_range(0, 2);
                memRd = (kind != 1); memWr = (kind != 0);
                mem_addr = 16'($urandom); mem_wdata = 16'($urandom);
            end
            if_req = ifAct; mem_read = memAct & memRd; mem_write = memAct & memWr;
            if (c >= freeAt && (ifAct || memAct)) begin
                winMem = memAct;
`ifdef MEM_ARB_FAIR_EN
                if (starved && ifAct) winMem = 0;
                starved = winMem && ifAct;
`endif
                gCyc = c; gMem = winMem; gAddr = winMem ? mem_addr : if_addr;
                gWe = winMem && memWr; gWdata = mem_wdata; gData = ramArr[gAddr[7:0]];
                busy = 1; freeAt = c + LAT + 2;
            end
            expEn     = busy && c > gCyc && c <= gCyc + LAT;
            expIfAck  = busy && !gMem && c == gCyc + LAT + 1;
            expMemAck = busy && gMem && c == gCyc + LAT + 1;
            if (expIfAck) expIf = gData;
            if (expMemAck && !gWe) expMem = gData;
            mid();
            check("rnd_en", ram_en, expEn);
            check("rnd_if_ack", if_ack, expIfAck);
            check("rnd_mem_ack", mem_ack, expMemAck);
            check("rnd_if_rdata", if_rdata, expIf);
            check("rnd_mem_rdata", mem_rdata, expMem);
            check("rnd_stall_if", stall_if, ifAct && !expIfAck);
            check("rnd_stall_mem", stall_mem, memAct && !expMemAck);
            if (expEn) begin
                check("rnd_addr", ram_addr, gAddr);
                check("rnd_we", ram_we, gWe);
                if (gWe) check("rnd_wdata", ram_wdata, gWdata);
            end
            if (expIfAck || expMemAck) begin
                if (gWe) ramArr[gAddr[7:0]] = gWdata;
                if (gMem) memAct = 0;
                else ifAct = 0;
                busy = 0;
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared data/instruction RAM port of the 16-bit pipeline. It grants the port to either the instruction-fetch requester (IF) or the memory stage (MEM), drives the multi-cycle RAM access, returns read data, and raises per-requester stall signals so the pipeline freezes while its request is pending. It sits between the fetch stage, the memory stage and the unified RAM.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `MEM_LAT`, 2: RAM access cycles; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch read request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_ack`  out  1  one-cycle pulse; `if_rdata` is valid in this cycle.
- `if_rdata`  out  DATA_W  fetched word.
- `mem_read`  in  1  memory-stage load request.
- `mem_write`  in  1  memory-stage store request.
- `mem_addr`  in  ADDR_W  load/store address (ALU result).
- `mem_wdata`  in  DATA_W  store data.
- `mem_ack`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  DATA_W  loaded word.
- `stall_if`  out  1  freeze fetch.
- `stall_mem`  out  1  freeze memory stage and upstream.
- `ram_en`  out  1  RAM access enable.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid on the last ACCESS cycle.

## Operation
- FSM states are IDLE, ACCESS and RESP. The owner register is IF or MEM, and `lat_cnt` is 4 bits.
- IDLE: if `mem_read|mem_write`, grant MEM; otherwise if `if_req`, grant IF; otherwise stay in IDLE.
- On a grant, latch owner, address, write data and `we` (= `mem_write` for MEM, 0 for IF). Load `lat_cnt = MEM_LAT-1` and go to ACCESS.
- ACCESS: drive `ram_en=1` and the latched `ram_we`, `ram_addr` and `ram_wdata`, all registered and stable for MEM_LAT cycles. Decrement `lat_cnt`.
- At `lat_cnt==0`, capture `ram_rdata` into the owner's rdata register if `we=0`, then go to RESP.
- RESP: pulse the owner's ack for one cycle, with `ram_en=0`. Return to IDLE. A new grant is possible in the following cycle.
- `mem_read` and `mem_write` both high: treated as a write. `mem_rdata` is not updated.
- If a request drops mid-access, the access still completes and the ack still pulses. The requester ignores it.
- `if_rdata` and `mem_rdata` hold their last captured values until the next read by the same owner.
- Stalls are combinational:
  - `stall_if = if_req & ~if_ack`
  - `stall_mem = (mem_read|mem_write) & ~mem_ack`
- Reset: state is IDLE and owner is IF. `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `if_ack`, `mem_ack`, `if_rdata` and `mem_rdata` are all 0.
- Reset mid-access abandons the access with no ack. Stalls follow requests during reset.

## Timing
- Grant at cycle 0 (IDLE with request). ACCESS runs cycles 1..MEM_LAT. Ack is at cycle MEM_LAT+1.
- Back-to-back period is MEM_LAT+2 cycles per access.
- Simultaneous IF and MEM requests: MEM is served first. IF is granted in the IDLE cycle after MEM's RESP, if MEM is then idle.
- The next request is sampled only in IDLE. Requests arriving during ACCESS or RESP wait.

## Configuration
- `MEM_ARB_FAIR_EN` defined: a `if_starved` flag is set when IF is pending at a MEM grant. When the flag is set and both requesters are pending in IDLE, IF wins and the flag clears. This gives strict alternation under contention and bounds IF wait to one MEM access.
- `MEM_ARB_FAIR_EN` undefined: MEM has fixed priority, and IF can starve under continuous MEM traffic.

## Test plan
All scenarios use `MEM_LAT=2`.
- **Reset:** `reset=1` with `if_req=1` and `mem_read=1` for 2 cycles.
  - All registered outputs are 0, `ram_en` stays 0, and there is no ack.
  - `stall_if=1` and `stall_mem=1`.
- **IF read:** `if_req=1`, `if_addr=0x0011`, RAM returns 0xBEEF.
  - `ram_en=1` with `ram_addr=0x0011` in cycles 1-2.
  - `if_ack` pulses in cycle 3 with `if_rdata=0xBEEF`.
  - `stall_if` is 1 in cycles 0-2 and 0 in cycle 3.
- **MEM store:** `mem_write=1`, `mem_addr=0x0004`, `mem_wdata=0xAAAA`.
  - `ram_we=1`, `ram_addr=0x0004` and `ram_wdata=0xAAAA` for 2 cycles.
  - `mem_ack` pulses in cycle 3, and `mem_rdata` is unchanged.
- **Contention:** `if_req=1` (0x0010) and `mem_read=1` (0x0004) in the same cycle.
  - MEM is served first, with `mem_ack` at cycle 3.
  - IF is granted at cycle 4, with `if_ack` at cycle 7.
- **Reset mid-access:** `reset=1` during the first ACCESS cycle of a MEM load.
  - The FSM returns to IDLE and `ram_en=0` next cycle.
  - No `mem_ack` is issued, and a fresh grant follows reset release.
- **Fairness (`MEM_ARB_FAIR_EN` set):** `mem_read` held high continuously with `if_req=1`.
  - Acks alternate MEM, IF, MEM, IF.
  - With the macro undefined, only `mem_ack` pulses.
